bram_burst_engine: RTL
======================

# bram_burst_engine

Burst initiator for one port of the on-chip dual-port BRAM. Accepts a single command (write or read, base address, word count) and converts it into one BRAM access per cycle, sourcing write data from a valid/ready stream and returning read data on a valid/ready stream. Read backpressure is absorbed by a 2-entry output buffer sized for the BRAM's 1-cycle read latency. Sits between DMA/accelerator logic and a BRAM port.

## Interface
- `DATA`, 32, word width
- `ADDR`, 10, BRAM address width; depth = 2**ADDR
- `clk` in 1, sole clock, rising edge
- `rst_n` in 1, asynchronous assert, active-low reset
- `cmd_valid` in 1, command offered
- `cmd_ready` out 1, command accepted when both high
- `cmd_wr` in 1, 1 = write burst, 0 = read burst
- `cmd_addr` in ADDR, base word address
- `cmd_len` in ADDR+1, word count, 0..2**ADDR
- `wd_valid` in 1, write word offered
- `wd_ready` out 1, write word consumed
- `wd_data` in DATA, write word
- `rd_valid` out 1, read word available
- `rd_ready` in 1, consumer accepts read word
- `rd_data` out DATA, read word
- `rd_last` out 1, marks final word of read burst
- `done` out 1, one-cycle pulse at burst completion
- `m_wr` out 1, BRAM write enable
- `m_addr` out ADDR, BRAM address
- `m_din` out DATA, BRAM write data
- `m_dout` in DATA, BRAM read data, valid the cycle after address presented

## Operation
- FSM states: IDLE, WRITE, READ. `cmd_ready` = (state == IDLE).
- On accept: latch address into `addr`, length into `remaining`, go to WRITE/READ. `cmd_len == 0`: no BRAM access, `done` pulses next cycle, stay IDLE.
- WRITE: `wd_ready` = 1; `m_wr` = `wd_valid`; `m_addr` = `addr`; `m_din` = `wd_data`. Each beat: `addr`++, `remaining`--. After the beat with `remaining == 1`: IDLE, `done` pulses.
- READ: issue (`m_addr` = `addr`, `m_wr` = 0) when `issued < len` and `occ + inflight - pop <= 1`; `occ` = buffer count, `inflight` = read issued last cycle, `pop` = `rd_valid & rd_ready`. On issue: `addr`++.
- `m_dout` is written into the buffer the cycle after issue. `rd_last` tags the word whose issue index == len-1.
- Completion: READ returns to IDLE and pulses `done` the cycle after the `rd_last` handshake.
- Address arithmetic is modulo 2**ADDR: a burst from 2**ADDR-2 of length 4 touches 1022, 1023, 0, 1 (ADDR=10).
- `m_addr`/`m_din` are don't-care when no access; `m_wr` is 0 outside WRITE.
- Async reset mid-burst: state IDLE, buffer flushed, in-flight read discarded, no `done`.

## Timing
- Reset values: `cmd_ready`=1, `wd_ready`=0, `rd_valid`=0, `rd_last`=0, `done`=0, `m_wr`=0.
- Command accepted at cycle 0. First BRAM access at cycle 1.
- Write: one word per cycle while `wd_valid` is held high. A len-N burst with no stalls has `done` at cycle N+1.
- Read: first `rd_valid` at cycle 3. With `rd_ready` held high, one word per cycle; last word at cycle N+2; `done` at N+3.
- `rd_data`/`rd_last` are stable while `rd_valid & !rd_ready`.
- Next command may be accepted in the `done` cycle.

## Structure
- Package `bram_burst_pkg`: FSM state enum (IDLE/WRITE/READ), buffer depth constant `RD_BUF_DEPTH = 2`.
- Sub-module `bram_rd_skid_fifo`: 2-entry FIFO of {DATA, last}, with push/pop/occ outputs. All FSM, counters and credit logic live in the top module.

## Test plan
- Write len=4 at addr 0x010, data 0xA0..0xA3, `wd_valid` constant -> `m_wr` high cycles 1-4, addrs 0x010-0x013, `done` at cycle 5. Read back len=4 with `rd_ready`=1 -> 0xA0..0xA3 at cycles 3-6, `rd_last` on 0xA3, `done` at cycle 7.
- Read len=8 with `rd_ready` toggling 1,0,0,1 -> no word lost or duplicated, `occ` never exceeds 2, `rd_data` stable during stalls.
- Write len=4 at addr 1022 (ADDR=10) -> `m_addr` sequence 1022, 1023, 0, 1.
- `cmd_len`=0 -> no `m_wr`/read issue, `done` pulse next cycle; `cmd_len`=1024 full sweep completes.
- Write with `wd_valid` gaps -> `m_wr` only on valid beats, `done` after the 4th beat.
- Assert `rst_n` low mid-read with 2 words buffered -> `rd_valid`=0 immediately, `cmd_ready`=1 after release, no `done`.

Source files
------------

// File: rtl/bram_burst_pkg.sv
// Shared types and constants for the BRAM burst engine.
package bram_burst_pkg;

  // Engine mode: idle/accepting, streaming writes, streaming reads.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  // Read buffer covers one BRAM read latency cycle plus one word of slack.
  localparam int RD_BUF_DEPTH = 2;
  localparam int RD_OCC_W     = $clog2(RD_BUF_DEPTH + 1);
  localparam int RD_PTR_W     = (RD_BUF_DEPTH > 1) ? $clog2(RD_BUF_DEPTH) : 1;

endpackage

// File: rtl/bram_rd_skid_fifo.sv
// Small FIFO holding returned read words {last, data} so the read stream
// can be stalled without losing the word already in flight from the BRAM.
module bram_rd_skid_fifo
  import bram_burst_pkg::*;
#(
  parameter int W = 33
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic [W-1:0]        push_data,
  input  logic                pop,
  output logic [W-1:0]        head,
  output logic                not_empty,
  output logic [RD_OCC_W-1:0] occ
);

  logic [W-1:0]        mem [RD_BUF_DEPTH];
  logic [RD_PTR_W-1:0] wr_ptr;
  logic [RD_PTR_W-1:0] rd_ptr;
  logic                push_ok;
  logic                pop_ok;

  assign not_empty = (occ != '0);
  assign push_ok   = push && (occ != RD_OCC_W'(RD_BUF_DEPTH));
  assign pop_ok    = pop && not_empty;
  assign head      = mem[rd_ptr];

  // Storage array; contents need no reset because occ gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; reset flushes everything buffered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + RD_PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + RD_PTR_W'(1);
      occ <= occ + RD_OCC_W'(push_ok) - RD_OCC_W'(pop_ok);
    end
  end

endmodule

// File: rtl/bram_burst_engine.sv
// Burst initiator for one BRAM port: turns a single write/read command into
// one BRAM access per cycle, with stream-side write data and read data.
//
// Handshakes (cmd, wd, rd) are all valid/ready: a transfer happens on the
// rising edge where both valid and ready are high; a producer holding valid
// keeps its payload stable until that edge.
module bram_burst_engine
  import bram_burst_pkg::*;
#(
  parameter int DATA = 32,
  parameter int ADDR = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_wr,
  input  logic [ADDR-1:0] cmd_addr,
  input  logic [ADDR:0]   cmd_len,
  input  logic            wd_valid,
  output logic            wd_ready,
  input  logic [DATA-1:0] wd_data,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [DATA-1:0] rd_data,
  output logic            rd_last,
  output logic            done,
  output logic            m_wr,
  output logic [ADDR-1:0] m_addr,
  output logic [DATA-1:0] m_din,
  input  logic [DATA-1:0] m_dout,
  output state_t          state
);

  localparam logic [ADDR:0] LEN_ONE = (ADDR+1)'(1);

  state_t              state_q;
  state_t              state_d;
  logic [ADDR-1:0]     addr_q;
  logic [ADDR:0]       remaining_q;
  logic [ADDR:0]       len_q;
  logic [ADDR:0]       issued_q;
  logic                inflight_q;
  logic                inflight_last_q;
  logic                done_q;

  logic                accept;
  logic                beat;
  logic                pop;
  logic                issue;
  logic [2:0]          credit;
  logic [DATA:0]       fifo_head;
  logic                fifo_not_empty;
  logic [RD_OCC_W-1:0] occ;

  assign accept = cmd_valid && (state_q == IDLE);
  assign beat   = (state_q == WRITE) && wd_valid;
  assign pop    = rd_valid && rd_ready;

  // Buffer slots already claimed once this cycle's pop and last cycle's read
  // return settle; a new read may issue only if one slot stays free for it.
  assign credit = 3'(occ) + 3'(inflight_q) - 3'(pop);

  assign rd_valid = fifo_not_empty;
  assign rd_data  = fifo_head[DATA-1:0];
  assign rd_last  = fifo_not_empty && fifo_head[DATA];
  assign done     = done_q;
  assign state    = state_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: zero-length commands complete without leaving IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && (cmd_len != '0)) state_d = cmd_wr ? WRITE : READ;
      end
      WRITE: begin
        if (beat && (remaining_q == LEN_ONE)) state_d = IDLE;
      end
      READ: begin
        if (pop && rd_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: handshakes, BRAM port drive and read issue gating.
  always_comb begin
    cmd_ready = (state_q == IDLE);
    wd_ready  = (state_q == WRITE);
    m_wr      = (state_q == WRITE) && wd_valid;
    m_addr    = addr_q;
    m_din     = wd_data;
    issue     = (state_q == READ) && (issued_q < len_q) && (credit <= 3'd1);
  end

  // Burst counters and address; the address wraps modulo the BRAM depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      remaining_q <= '0;
      len_q       <= '0;
      issued_q    <= '0;
    end else if (accept) begin
      addr_q      <= cmd_addr;
      remaining_q <= cmd_len;
      len_q       <= cmd_len;
      issued_q    <= '0;
    end else if (beat) begin
      addr_q      <= addr_q + ADDR'(1);
      remaining_q <= remaining_q - LEN_ONE;
    end else if (issue) begin
      addr_q      <= addr_q + ADDR'(1);
      issued_q    <= issued_q + LEN_ONE;
    end
  end

  // Read-return tracking and the completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      inflight_q      <= issue;
      inflight_last_q <= issue && (issued_q == (len_q - LEN_ONE));
      done_q          <= (accept && (cmd_len == '0)) ||
                         (beat && (remaining_q == LEN_ONE)) ||
                         (pop && rd_last);
    end
  end

  bram_rd_skid_fifo #(
    .W (DATA + 1)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data ({inflight_last_q, m_dout}),
    .pop       (pop),
    .head      (fifo_head),
    .not_empty (fifo_not_empty),
    .occ       (occ)
  );

endmodule
